// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared constants and types for the ALU issue controller
package alu_issue_ctrl_pkg;

    localparam int DW    = 32;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8x32 register file, r0 hardwired to zero, one write and three read ports
module alu_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] ra3,
    output logic [DW-1:0] rd3
);

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];
    assign rd3 = regs_q[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - three-phase issue/writeback controller feeding an external combinational ALU
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          done_valid,
    output logic [AW-1:0] done_rd,
    output logic [DW-1:0] done_result,
    output logic          done_zero,
    output logic          done_illegal
);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs1_q, rs1_d;
    logic [AW-1:0] rs2_q, rs2_d;
    logic [DW-1:0] res_q, res_d;
    logic          zero_q, zero_d;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;

    alu_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .ra1   (rs1_q),
        .rd1   (rf_rd1),
        .ra2   (rs2_q),
        .rd2   (rf_rd2),
        .ra3   (rd_addr),
        .rd3   (rd_data)
    );

    // The write port is shared: loads own it in IDLE, writeback owns it in WB.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        res_d    = res_q;
        zero_d   = zero_q;
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        case (state_q)
            ST_IDLE: begin
                rf_we = ld_en;
                if (in_valid) begin
                    op_d    = in_op;
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign alu_a        = (state_q == ST_EXEC) ? rf_rd1 : '0;
    assign alu_b        = (state_q == ST_EXEC) ? rf_rd2 : '0;
    assign alu_ctrl     = (state_q == ST_EXEC) ? op_q : 3'b000;
    assign done_valid   = (state_q == ST_WB);
    assign done_rd      = (state_q == ST_WB) ? rd_q : '0;
    assign done_result  = (state_q == ST_WB) ? res_q : '0;
    assign done_zero    = (state_q == ST_WB) && zero_q;
    assign done_illegal = (state_q == ST_WB) && op_q[2];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - table-driven self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        done_valid;
    logic [2:0]  done_rd;
    logic [31:0] done_result;
    logic        done_zero;
    logic        done_illegal;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .done_valid   (done_valid),
        .done_rd      (done_rd),
        .done_result  (done_result),
        .done_zero    (done_zero),
        .done_illegal (done_illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic run_vec(input vec_t v);
        in_op = v.op;
        in_rd = v.rd;
        in_rs1 = v.rs1;
        in_rs2 = v.rs2;
        in_valid = 1'b1;
        chk("ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("exec_ready", 32'(in_ready), 32'd0);
        chk("exec_done", 32'(done_valid), 32'd0);
        chk("exec_ctrl", 32'(alu_ctrl), 32'(v.op));
        tick();
        chk("wb_done", 32'(done_valid), 32'd1);
        chk("wb_rd", 32'(done_rd), 32'(v.rd));
        chk("wb_result", done_result, v.exp_res);
        chk("wb_zero", 32'(done_zero), 32'(v.exp_zero));
        chk("wb_illegal", 32'(done_illegal), 32'(v.exp_ill));
        tick();
        chk("post_done", 32'(done_valid), 32'd0);
        chk("post_ready", 32'(in_ready), 32'd1);
        read_chk("rf_dest", v.rd, (v.rd == 3'd0) ? 32'h0 : v.exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b000, 3'd3, 3'd1, 3'd2, 32'd5,        32'd7,        32'd12,        1'b0, 1'b0};
        vecs[1] = '{3'b011, 3'd5, 3'd4, 3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,         1'b1, 1'b0};
        vecs[2] = '{3'b000, 3'd7, 3'd6, 3'd1, 32'hFFFFFFFF, 32'd1,        32'h0,         1'b1, 1'b0};
        vecs[3] = '{3'b001, 3'd3, 3'd1, 3'd2, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234,  1'b0, 1'b0};
        vecs[4] = '{3'b010, 3'd4, 3'd5, 3'd6, 32'h80000000, 32'h00000001, 32'h80000001,  1'b0, 1'b0};
        vecs[5] = '{3'b101, 3'd3, 3'd1, 3'd2, 32'd5,        32'd7,        32'h0,         1'b1, 1'b1};
        vecs[6] = '{3'b000, 3'd0, 3'd1, 3'd2, 32'd5,        32'd7,        32'd12,        1'b0, 1'b0};
        vecs[7] = '{3'b000, 3'd1, 3'd1, 3'd2, 32'd3,        32'd4,        32'd7,         1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rd_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        for (int r = 0; r < 8; r++) read_chk("rst_rf", 3'(r), 32'h0);

        for (int i = 0; i < 8; i++) begin
            load(vecs[i].rs1, vecs[i].va);
            if (vecs[i].rs2 != vecs[i].rs1) load(vecs[i].rs2, vecs[i].vb);
            run_vec(vecs[i]);
        end
        read_chk("r0_zero", 3'd0, 32'h0);

        // Back-to-back: in_valid held high, a load attempted mid-EXEC must be ignored.
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        in_op = 3'b000;
        in_rd = 3'd3;
        in_rs1 = 3'd1;
        in_rs2 = 3'd2;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c <= 6);
            ld_en = (c == 1);
            ld_addr = 3'd1;
            ld_data = 32'd100;
            chk("b2b_ready", 32'(in_ready), ((c % 3) == 0) ? 32'd1 : 32'd0);
            chk("b2b_done", 32'(done_valid), ((c % 3) == 2) ? 32'd1 : 32'd0);
            if ((c % 3) == 2) chk("b2b_result", done_result, 32'd12);
            tick();
        end
        in_valid = 1'b0;
        ld_en = 1'b0;
        read_chk("b2b_r1_kept", 3'd1, 32'd5);

        // Load coincident with accept, then an immediately dependent command.
        ld_en = 1'b1;
        ld_addr = 3'd1;
        ld_data = 32'd9;
        in_valid = 1'b1;
        in_op = 3'b000;
        in_rd = 3'd2;
        in_rs1 = 3'd1;
        in_rs2 = 3'd1;
        tick();
        ld_en = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("coin_done", 32'(done_valid), 32'd1);
        chk("coin_result", done_result, 32'd18);
        tick();
        in_valid = 1'b1;
        in_op = 3'b010;
        in_rd = 3'd3;
        in_rs1 = 3'd2;
        in_rs2 = 3'd0;
        chk("dep_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("dep_done", 32'(done_valid), 32'd1);
        chk("dep_result", done_result, 32'd18);
        tick();
        read_chk("dep_rf", 3'd3, 32'd18);

        // Reset while in EXEC: command dropped, register file cleared.
        in_valid = 1'b1;
        in_op = 3'b000;
        in_rd = 3'd4;
        in_rs1 = 3'd1;
        in_rs2 = 3'd2;
        tick();
        in_valid = 1'b0;
        chk("mid_exec_ctrl_a", alu_a, 32'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_done", 32'(done_valid), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'h0);
        tick();
        chk("mid_rst_done2", 32'(done_valid), 32'd0);
        for (int r = 0; r < 8; r++) read_chk("mid_rst_rf", 3'(r), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
